// File: rtl/divider_pkg.sv
// Shared types and width constants for the restoring divider.
package divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module divider_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  // The shifted partial remainder needs one extra bit; after a conditional
  // subtract it is always below the divisor and fits back in DIVISOR_W bits.
  logic [DIVISOR_W:0] r_shift;
  logic               fits;

  // Shift, compare and conditionally subtract.
  always_comb begin
    r_shift = {rem_i, bit_i};
    fits    = (r_shift >= {1'b0, divisor_i});
    q_bit_o = fits;
    if (fits) begin
      rem_o = DIVISOR_W'(r_shift - {1'b0, divisor_i});
    end else begin
      rem_o = r_shift[DIVISOR_W-1:0];
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with a
// start/busy/valid handshake.
module divider #(
  parameter int DIVIDEND_W = divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = divider_pkg::DIVISOR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  import divider_pkg::*;

  localparam int CNT_W_L = $clog2(DIVIDEND_W);

  state_t                state;
  logic [CNT_W_L-1:0]    cnt;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVIDEND_W-1:0] quot_w;
  logic [DIVISOR_W-1:0]  rem_w;

  logic [DIVISOR_W-1:0]  rem_next;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] quot_next;

  // Dividend bits are consumed MSB first from the shifting operand register.
  divider_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_w),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_next),
    .q_bit_o   (q_bit)
  );

  assign quot_next = {quot_w[DIVIDEND_W-2:0], q_bit};

  // Control FSM, iteration counter, working registers and registered results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      quot_w        <= '0;
      rem_w         <= '0;
      busy_o        <= 1'b0;
      valid_o       <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            valid_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            dvd_q         <= dividend_i;
            dvs_q         <= divisor_i;
            quot_w        <= '0;
            rem_w         <= '0;
            if (divisor_i == '0) begin
              // Nothing to iterate: report saturated quotient immediately.
              state         <= DONE;
              valid_o       <= 1'b1;
              div_by_zero_o <= 1'b1;
              quotient_o    <= '1;
              remainder_o   <= '0;
            end else begin
              state  <= CALC;
              busy_o <= 1'b1;
              cnt    <= CNT_W_L'(DIVIDEND_W - 1);
            end
          end
        end
        CALC: begin
          dvd_q  <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          quot_w <= quot_next;
          rem_w  <= rem_next;
          cnt    <= cnt - CNT_W_L'(1);
          if (cnt == '0) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            valid_o     <= 1'b1;
            quotient_o  <= quot_next;
            remainder_o <= rem_next;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
